grid_game_core: RTL and testbench

GRID_GAME_CORE -- requirements
Module: grid_game_core

---
 rtl/grid_game_core.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_grid_game_core.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_game_core.sv
// Turn-based SIZE x SIZE grid game: move arbitration, line-scan win check,
// draw detection and a BCD per-move countdown that forfeits the turn on expiry.
module grid_game_core #(
    parameter int SIZE       = 3,
    parameter int WIN_LEN    = 3,
    parameter int TIME_LIMIT = 30,
    parameter int TICK_DIV   = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       restart,
    input  logic       move_valid,
    input  logic [2:0] move_row,
    input  logic [2:0] move_col,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [1:0] rd_cell,
    output logic       turn,
    output logic [1:0] game_end,
    output logic [3:0] time_left_ten,
    output logic [3:0] time_left_one,
    output logic       move_accept,
    output logic       move_reject,
    output logic       busy
);

    localparam int CNT_W = $clog2(SIZE * SIZE + 1);
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [3:0]       TL_TEN   = 4'(TIME_LIMIT / 10);
    localparam logic [3:0]       TL_ONE   = 4'(TIME_LIMIT % 10);
    localparam logic [3:0]       STEP_MAX = 4'(WIN_LEN - 1);
    localparam logic [3:0]       SIZE_L   = 4'(SIZE);
    localparam logic [CNT_W-1:0] CELLS    = CNT_W'(SIZE * SIZE);
    localparam logic [PS_W-1:0]  PS_MAX   = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        board_q [0:7][0:7];
    logic [1:0]        board_d [0:7][0:7];
    logic              turn_q, turn_d;
    logic [1:0]        game_end_q, game_end_d;
    logic [3:0]        ten_q, ten_d;
    logic [3:0]        one_q, one_d;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic              rej_q, rej_d;
    logic              busy_q, busy_d;
    logic [2:0]        pr_q, pr_d, pc_q, pc_d;
    logic [2:0]        cr_q, cr_d, cc_q, cc_d;
    logic [1:0]        dir_q, dir_d;
    logic              sense_q, sense_d;
    logic [3:0]        step_q, step_d;
    logic [3:0]        run_q, run_d;

    logic [1:0]        mark_s;
    logic              move_ok_s;
    logic              accept_s;
    logic signed [4:0] base_r_s, base_c_s;
    logic signed [4:0] nr_s, nc_s;
    logic              in_range_s;
    logic              own_s;
    logic              win_s;
    logic              sense_end_s;

    assign mark_s    = turn_q ? 2'b10 : 2'b01;
    assign move_ok_s = ({1'b0, move_row} < SIZE_L) && ({1'b0, move_col} < SIZE_L)
                       && (board_q[move_row][move_col] == 2'b00);
    assign accept_s  = (state_q == PLAY) && move_valid && move_ok_s;

    assign rd_cell = (({1'b0, rd_row} < SIZE_L) && ({1'b0, rd_col} < SIZE_L))
                     ? board_q[rd_row][rd_col] : 2'b00;

    assign turn          = turn_q;
    assign game_end      = game_end_q;
    assign time_left_ten = ten_q;
    assign time_left_one = one_q;
    assign move_accept   = acc_q;
    assign move_reject   = rej_q;
    assign busy          = busy_q;

    // Scan step vector for the current direction; sense 1 walks the opposite way.
    always_comb begin
        base_r_s = 5'sd0;
        base_c_s = 5'sd0;
        case (dir_q)
            2'd0: begin base_r_s = 5'sd0; base_c_s = 5'sd1;  end
            2'd1: begin base_r_s = 5'sd1; base_c_s = 5'sd0;  end
            2'd2: begin base_r_s = 5'sd1; base_c_s = 5'sd1;  end
            2'd3: begin base_r_s = 5'sd1; base_c_s = -5'sd1; end
            default: begin base_r_s = 5'sd0; base_c_s = 5'sd0; end
        endcase
        nr_s = sense_q ? ($signed({2'b00, cr_q}) - base_r_s) : ($signed({2'b00, cr_q}) + base_r_s);
        nc_s = sense_q ? ($signed({2'b00, cc_q}) - base_c_s) : ($signed({2'b00, cc_q}) + base_c_s);
        in_range_s = (nr_s >= 5'sd0) && (nr_s < $signed({1'b0, SIZE_L}))
                     && (nc_s >= 5'sd0) && (nc_s < $signed({1'b0, SIZE_L}));
        own_s = in_range_s && (board_q[nr_s[2:0]][nc_s[2:0]] == mark_s);
    end

    // A sense ends on a foreign/out-of-board cell or after WIN_LEN-1 steps.
    always_comb begin
        win_s       = 1'b0;
        sense_end_s = 1'b0;
        if (own_s) begin
            win_s       = (run_q + 4'd1) >= STEP_MAX;
            sense_end_s = (step_q + 4'd1) >= STEP_MAX;
        end else begin
            sense_end_s = 1'b1;
        end
    end

    // Next-state logic for the game FSM, board, timer and scan pointers.
    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        turn_d     = turn_q;
        game_end_d = game_end_q;
        ten_d      = ten_q;
        one_d      = one_q;
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        pr_d       = pr_q;
        pc_d       = pc_q;
        cr_d       = cr_q;
        cc_d       = cc_q;
        dir_d      = dir_q;
        sense_d    = sense_q;
        step_d     = step_q;
        run_d      = run_q;
        acc_d      = 1'b0;
        rej_d      = 1'b0;

        if (restart) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    board_d[r][c] = 2'b00;
                end
            end
            state_d    = PLAY;
            turn_d     = 1'b0;
            game_end_d = 2'b00;
            ten_d      = TL_TEN;
            one_d      = TL_ONE;
            presc_d    = {PS_W{1'b0}};
            cnt_d      = {CNT_W{1'b0}};
            dir_d      = 2'd0;
            sense_d    = 1'b0;
            step_d     = 4'd0;
            run_d      = 4'd0;
        end else begin
            rej_d = move_valid && !accept_s;
            case (state_q)
                PLAY: begin
                    if (accept_s) begin
                        board_d[move_row][move_col] = mark_s;
                        cnt_d   = (cnt_q == CELLS) ? cnt_q : (cnt_q + CNT_W'(1'b1));
                        acc_d   = 1'b1;
                        pr_d    = move_row;
                        pc_d    = move_col;
                        cr_d    = move_row;
                        cc_d    = move_col;
                        dir_d   = 2'd0;
                        sense_d = 1'b0;
                        step_d  = 4'd0;
                        run_d   = 4'd0;
                        state_d = CHECK;
                    end else if (presc_q == PS_MAX) begin
                        presc_d = {PS_W{1'b0}};
                        // Expiry never shows 00: the turn passes and the clock reloads at once.
                        if ((ten_q == 4'd0) && (one_q == 4'd1)) begin
                            turn_d = ~turn_q;
                            ten_d  = TL_TEN;
                            one_d  = TL_ONE;
                        end else if (one_q == 4'd0) begin
                            one_d = 4'd9;
                            ten_d = ten_q - 4'd1;
                        end else begin
                            one_d = one_q - 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + PS_W'(1'b1);
                    end
                end
                CHECK: begin
                    if (win_s) begin
                        game_end_d = turn_q ? 2'b10 : 2'b01;
                        state_d    = DONE;
                    end else if (sense_end_s) begin
                        cr_d   = pr_q;
                        cc_d   = pc_q;
                        step_d = 4'd0;
                        if (!sense_q) begin
                            sense_d = 1'b1;
                            run_d   = run_q + {3'b000, own_s};
                        end else if (dir_q == 2'd3) begin
                            if (cnt_q == CELLS) begin
                                game_end_d = 2'b11;
                                state_d    = DONE;
                            end else begin
                                turn_d  = ~turn_q;
                                ten_d   = TL_TEN;
                                one_d   = TL_ONE;
                                presc_d = {PS_W{1'b0}};
                                state_d = PLAY;
                            end
                        end else begin
                            dir_d   = dir_q + 2'd1;
                            sense_d = 1'b0;
                            run_d   = 4'd0;
                        end
                    end else begin
                        run_d  = run_q + 4'd1;
                        step_d = step_q + 4'd1;
                        cr_d   = nr_s[2:0];
                        cc_d   = nc_s[2:0];
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
        busy_d = (state_d == CHECK);
    end

    // State register with asynchronous reset to an empty board and full clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    board_q[r][c] <= 2'b00;
                end
            end
            state_q    <= PLAY;
            turn_q     <= 1'b0;
            game_end_q <= 2'b00;
            ten_q      <= TL_TEN;
            one_q      <= TL_ONE;
            presc_q    <= {PS_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= 1'b0;
            rej_q      <= 1'b0;
            busy_q     <= 1'b0;
            pr_q       <= 3'd0;
            pc_q       <= 3'd0;
            cr_q       <= 3'd0;
            cc_q       <= 3'd0;
            dir_q      <= 2'd0;
            sense_q    <= 1'b0;
            step_q     <= 4'd0;
            run_q      <= 4'd0;
        end else begin
            board_q    <= board_d;
            state_q    <= state_d;
            turn_q     <= turn_d;
            game_end_q <= game_end_d;
            ten_q      <= ten_d;
            one_q      <= one_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rej_q      <= rej_d;
            busy_q     <= busy_d;
            pr_q       <= pr_d;
            pc_q       <= pc_d;
            cr_q       <= cr_d;
            cc_q       <= cc_d;
            dir_q      <= dir_d;
            sense_q    <= sense_d;
            step_q     <= step_d;
            run_q      <= run_d;
        end
    end

endmodule

// File: tb/tb_grid_game_core.sv
// Directed bench for grid_game_core: three instances (default 3x3, short timer, 5x5/WIN4).
module tb_grid_game_core;

    logic       clock = 1'b0;
    logic       reset;
    logic       restart;
    logic [2:0] move_row, move_col, rd_row, rd_col;
    logic       mv       [3];
    logic [1:0] rd_cell  [3];
    logic       turn     [3];
    logic [1:0] game_end [3];
    logic [3:0] t_ten    [3];
    logic [3:0] t_one    [3];
    logic       acc      [3];
    logic       rej      [3];
    logic       busy     [3];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    grid_game_core u_std (
        .clock(clock), .reset(reset), .restart(restart), .move_valid(mv[0]),
        .move_row(move_row), .move_col(move_col), .rd_row(rd_row), .rd_col(rd_col),
        .rd_cell(rd_cell[0]), .turn(turn[0]), .game_end(game_end[0]),
        .time_left_ten(t_ten[0]), .time_left_one(t_one[0]),
        .move_accept(acc[0]), .move_reject(rej[0]), .busy(busy[0])
    );

    grid_game_core #(.SIZE(3), .WIN_LEN(3), .TIME_LIMIT(2), .TICK_DIV(4)) u_tmr (
        .clock(clock), .reset(reset), .restart(restart), .move_valid(mv[1]),
        .move_row(move_row), .move_col(move_col), .rd_row(rd_row), .rd_col(rd_col),
        .rd_cell(rd_cell[1]), .turn(turn[1]), .game_end(game_end[1]),
        .time_left_ten(t_ten[1]), .time_left_one(t_one[1]),
        .move_accept(acc[1]), .move_reject(rej[1]), .busy(busy[1])
    );

    grid_game_core #(.SIZE(5), .WIN_LEN(4)) u_big (
        .clock(clock), .reset(reset), .restart(restart), .move_valid(mv[2]),
        .move_row(move_row), .move_col(move_col), .rd_row(rd_row), .rd_col(rd_col),
        .rd_cell(rd_cell[2]), .turn(turn[2]), .game_end(game_end[2]),
        .time_left_ten(t_ten[2]), .time_left_one(t_one[2]),
        .move_accept(acc[2]), .move_reject(rej[2]), .busy(busy[2])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One move pulse; returns accept/reject and how many cycles busy stayed high.
    task automatic apply_move(input int d, input int r, input int c,
                              output logic a, output logic j, output int bw);
        @(negedge clock);
        move_row = 3'(r);
        move_col = 3'(c);
        mv[d]    = 1'b1;
        @(posedge clock);
        #1;
        a = acc[d];
        j = rej[d];
        @(negedge clock);
        mv[d] = 1'b0;
        bw = 0;
        while (busy[d] && bw < 100) begin
            @(posedge clock);
            #1;
            bw++;
        end
        check_val("busy_bound", 32'(bw < 100), 32'd1);
    endtask

    task automatic peek(input int d, input int r, input int c, output logic [1:0] v);
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        v = rd_cell[d];
    endtask

    task automatic do_restart();
        @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       a, j;
        logic [1:0] v;
        int         bw;
        int         dr [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        int         dc [9] = '{0, 1, 2, 1, 0, 2, 1, 0, 2};
        int         br [7] = '{0, 4, 1, 4, 2, 4, 3};
        int         bc [7] = '{0, 0, 1, 1, 2, 2, 3};

        reset    = 1'b1;
        restart  = 1'b0;
        move_row = 3'd0;
        move_col = 3'd0;
        rd_row   = 3'd0;
        rd_col   = 3'd0;
        for (int i = 0; i < 3; i++) mv[i] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_turn", 32'(turn[0]), 32'd0);
        check_val("rst_end", 32'(game_end[0]), 32'd0);
        check_val("rst_ten", 32'(t_ten[0]), 32'd3);
        check_val("rst_one", 32'(t_one[0]), 32'd0);
        check_val("rst_busy", 32'(busy[0]), 32'd0);
        check_val("rst_acc", 32'(acc[0]), 32'd0);
        check_val("rst_rej", 32'(rej[0]), 32'd0);
        check_val("rst_tmr_one", 32'(t_one[1]), 32'd2);
        @(negedge clock);
        reset = 1'b0;

        // Row-0 win for player 1
        apply_move(0, 0, 0, a, j, bw);
        check_val("w_acc1", 32'(a), 32'd1);
        check_val("w_bw1", 32'(bw <= 17 && bw > 0), 32'd1);
        check_val("w_turn1", 32'(turn[0]), 32'd1);
        apply_move(0, 1, 0, a, j, bw);
        check_val("w_acc2", 32'(a), 32'd1);
        check_val("w_turn2", 32'(turn[0]), 32'd0);
        apply_move(0, 0, 1, a, j, bw);
        apply_move(0, 1, 1, a, j, bw);
        check_val("w_end_mid", 32'(game_end[0]), 32'd0);
        apply_move(0, 0, 2, a, j, bw);
        check_val("w_acc5", 32'(a), 32'd1);
        check_val("w_end", 32'(game_end[0]), 32'd1);
        check_val("w_turn", 32'(turn[0]), 32'd0);
        apply_move(0, 2, 2, a, j, bw);
        check_val("done_rej", 32'(j), 32'd1);
        check_val("done_acc", 32'(a), 32'd0);
        peek(0, 0, 0, v); check_val("rd_00", 32'(v), 32'd1);
        peek(0, 1, 0, v); check_val("rd_10", 32'(v), 32'd2);
        peek(0, 2, 2, v); check_val("rd_22", 32'(v), 32'd0);
        peek(0, 3, 0, v); check_val("rd_oob", 32'(v), 32'd0);

        // Occupied and out-of-range rejects
        do_restart();
        check_val("rs_end", 32'(game_end[0]), 32'd0);
        peek(0, 0, 0, v); check_val("rs_rd00", 32'(v), 32'd0);
        apply_move(0, 0, 0, a, j, bw);
        check_val("r_acc", 32'(a), 32'd1);
        apply_move(0, 0, 0, a, j, bw);
        check_val("r_occ_rej", 32'(j), 32'd1);
        check_val("r_occ_acc", 32'(a), 32'd0);
        apply_move(0, 3, 0, a, j, bw);
        check_val("r_oob_rej", 32'(j), 32'd1);
        check_val("r_turn", 32'(turn[0]), 32'd1);
        check_val("r_ten", 32'(t_ten[0]), 32'd3);
        check_val("r_one", 32'(t_one[0]), 32'd0);
        peek(0, 0, 0, v); check_val("r_rd00", 32'(v), 32'd1);

        // Draw: X O X / X O O / O X X
        do_restart();
        for (int i = 0; i < 9; i++) begin
            apply_move(0, dr[i], dc[i], a, j, bw);
            check_val("d_acc", 32'(a), 32'd1);
            check_val("d_end", 32'(game_end[0]), (i == 8) ? 32'd3 : 32'd0);
        end

        // Timeout forfeit on the short-timer instance
        @(negedge clock);
        restart = 1'b1;
        @(posedge clock);
        #1;
        check_val("t_ld_one", 32'(t_one[1]), 32'd2);
        check_val("t_ld_ten", 32'(t_ten[1]), 32'd0);
        check_val("t_ld_turn", 32'(turn[1]), 32'd0);
        @(negedge clock);
        restart = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("t_c3", 32'(t_one[1]), 32'd2);
        @(posedge clock);
        #1;
        check_val("t_c4", 32'(t_one[1]), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        check_val("t_c7_turn", 32'(turn[1]), 32'd0);
        check_val("t_c7_one", 32'(t_one[1]), 32'd1);
        @(posedge clock);
        #1;
        check_val("t_c8_turn", 32'(turn[1]), 32'd1);
        check_val("t_c8_one", 32'(t_one[1]), 32'd2);
        check_val("t_c8_ten", 32'(t_ten[1]), 32'd0);

        // 5x5 / WIN4 diagonal win
        do_restart();
        for (int i = 0; i < 7; i++) begin
            apply_move(2, br[i], bc[i], a, j, bw);
            check_val("b_acc", 32'(a), 32'd1);
            check_val("b_end", 32'(game_end[2]), (i == 6) ? 32'd1 : 32'd0);
        end
        check_val("b_bw", 32'(bw <= 25 && bw > 0), 32'd1);
        check_val("b_turn", 32'(turn[2]), 32'd0);

        // Reset while a scan is in flight
        do_restart();
        @(negedge clock);
        move_row = 3'd0;
        move_col = 3'd0;
        mv[0]    = 1'b1;
        @(posedge clock);
        #1;
        check_val("m_acc", 32'(acc[0]), 32'd1);
        check_val("m_busy", 32'(busy[0]), 32'd1);
        @(negedge clock);
        move_row = 3'd2;
        move_col = 3'd2;
        @(posedge clock);
        #1;
        check_val("m_chk_rej", 32'(rej[0]), 32'd1);
        @(negedge clock);
        mv[0] = 1'b0;
        reset = 1'b1;
        #1;
        check_val("m_rst_busy", 32'(busy[0]), 32'd0);
        check_val("m_rst_rej", 32'(rej[0]), 32'd0);
        peek(0, 0, 0, v); check_val("m_rst_rd", 32'(v), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check_val("m_post_turn", 32'(turn[0]), 32'd0);
        check_val("m_post_busy", 32'(busy[0]), 32'd0);
        check_val("m_post_end", 32'(game_end[0]), 32'd0);
        check_val("m_post_ten", 32'(t_ten[0]), 32'd3);
        apply_move(0, 1, 1, a, j, bw);
        check_val("m_next_acc", 32'(a), 32'd1);
        peek(0, 1, 1, v); check_val("m_next_rd", 32'(v), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
